multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum consecutive mem_ready-low cycles tolerated in FETCH or MEM before the error state.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 run  input  1  1 = execute instructions; 0 = halt in IDLE after the current instruction.
REQ-005 inst  input  32  instruction register contents; opcode = inst[6:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completes the current request this cycle.
REQ-008 state  output  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
REQ-009 mem_req, mem_we, iord  output  1 each  memory request, write strobe, address select (0 = PC, 1 = ALU result register).
REQ-010 ir_w_en, pc_w_en, pc_src  output  1 each  IR/old_pc load, PC load, PC source (0 = ALU result, 1 = branch/jump target).
REQ-011 alu_src1_is_pc  output  1  ALU operand 1 = PC (FETCH) or old_pc (EXEC).
REQ-012 alu_src2_sel  output  2  00 = rs2, 01 = immediate, 10 = constant 4.
REQ-013 alu_op  output  1  0 = add, 1 = subtract.
REQ-014 imm_type  output  3  I/S/B/J/R immediate-type codes from the shared parameter header.
REQ-015 reg_w_en, mem_to_reg  output  1 each  register-file write enable, write-back source = memory.
REQ-016 retire, err  output  1 each  one-cycle pulse on instruction completion; sticky error flag.
REQ-017 cycle_cnt, inst_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-018 Supported opcodes: lw 0x03, addi 0x13, sw 0x23, add 0x33, beq 0x63, jal 0x6F; any other opcode in DECODE shall go to ERR.
REQ-019 IDLE: all strobes 0; run=1 -> FETCH next cycle.
REQ-020 FETCH: mem_req=1, iord=0, alu_src1_is_pc=1, alu_src2_sel=10, alu_op=0; when mem_ready=1: ir_w_en=1, pc_w_en=1, pc_src=0, -> DECODE.
REQ-021 DECODE: one cycle, no strobes; drives imm_type; -> EXEC or ERR.
REQ-022 EXEC add/addi: alu_src2_sel 00/01, alu_op=0 -> WB.
REQ-023 EXEC lw/sw: alu_src2_sel=01, alu_op=0 -> MEM.
REQ-024 EXEC beq: alu_src2_sel=00, alu_op=1; pc_w_en=zero, pc_src=1; retire=1 -> next state per REQ-028.
REQ-025 EXEC jal: alu_src1_is_pc=1, alu_src2_sel=10, reg_w_en=1, pc_w_en=1, pc_src=1; retire=1 -> next state per REQ-028.
REQ-026 MEM: mem_req=1, iord=1, mem_we=1 for sw; on mem_ready: sw retires (next per REQ-028), lw -> WB.
REQ-027 WB: reg_w_en=1, mem_to_reg=1 for lw only; retire=1 -> next per REQ-028.
REQ-028 After a retire: run=1 -> FETCH, run=0 -> IDLE; run deasserted mid-instruction does not abort it.
REQ-029 Wait counter: clears on entry to FETCH/MEM and on mem_ready=1; increments each cycle mem_ready=0; reaching WAIT_MAX -> ERR with no strobe issued that cycle.
REQ-030 ERR: err=1, all strobes 0, no exit except reset.
REQ-031 All strobes decoded combinationally from state, inst and mem_ready; mem_we, ir_w_en, pc_w_en never asserted outside the states listed.

Reset
REQ-032 rst=1 shall immediately force state=IDLE, wait counter=0, err=0, counters=0 and all strobes 0, including mid-MEM with mem_we high.

Configuration
REQ-033 Macro PERF_CNT_EN defined: cycle_cnt increments every cycle in FETCH..WB, inst_cnt increments on each retire, both wrap at 2^32-1 -> 0.
REQ-034 PERF_CNT_EN undefined: ports remain, driven constant 0, no counter flops.

Verification
REQ-035 Reset, run=1, inst=0x00500093 (addi), mem_ready=1 -> states 1,2,3,5,1; retire pulse in WB; reg_w_en=1 only in WB.
REQ-036 inst=0x0000A103 (lw), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, then WB with mem_to_reg=1.
REQ-037 inst=0x00208463 (beq) with zero=1 -> pc_w_en=1, pc_src=1 in EXEC; zero=0 -> pc_w_en=0; both retire.
REQ-038 mem_ready=0 for 15 cycles in FETCH -> state=6, err=1 until rst.
REQ-039 inst=0xFFFFFFFF -> DECODE to ERR; rst asserted in MEM of sw -> mem_we drops same cycle, state=0.
REQ-040 PERF_CNT_EN defined, 3 addi instructions -> inst_cnt=3, cycle_cnt=12.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-wait timeout.
// Define PERF_CNT_EN to build the cycle/instruction performance counters; otherwise they read 0.
package multicycle_ctrl_pkg;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_ERR    = 3'd6
   } state_e;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_R = 3'd4;

   localparam logic [6:0] OP_LW   = 7'h03;
   localparam logic [6:0] OP_ADDI = 7'h13;
   localparam logic [6:0] OP_SW   = 7'h23;
   localparam logic [6:0] OP_ADD  = 7'h33;
   localparam logic [6:0] OP_BEQ  = 7'h63;
   localparam logic [6:0] OP_JAL  = 7'h6F;
endpackage

module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [31:0] inst,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [2:0]  state,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_w_en,
   output logic        pc_w_en,
   output logic        pc_src,
   output logic        alu_src1_is_pc,
   output logic [1:0]  alu_src2_sel,
   output logic        alu_op,
   output logic [2:0]  imm_type,
   output logic        reg_w_en,
   output logic        mem_to_reg,
   output logic        retire,
   output logic        err,
   output logic [31:0] cycle_cnt,
   output logic [31:0] inst_cnt
);
   localparam int WW = $clog2(WAIT_MAX + 1);

   state_e        state_q, state_d, retire_next;
   logic [WW-1:0] wait_q, wait_d;
   logic [6:0]    opcode;
   logic          mem_wait_state;
   logic          timeout;
   logic          unused_inst_bits;

   assign opcode           = inst[6:0];
   // Operand and immediate fields are consumed by the datapath, not the controller.
   assign unused_inst_bits = ^inst[31:7];
   assign mem_wait_state   = (state_q == ST_FETCH) || (state_q == ST_MEM);
   assign timeout          = mem_wait_state && !mem_ready && (wait_q == WW'(WAIT_MAX - 1));
   assign retire_next      = run ? ST_FETCH : ST_IDLE;

   always_comb begin
      wait_d = '0;
      if (mem_wait_state && !mem_ready && !timeout) wait_d = wait_q + WW'(1);
   end

   always_comb begin
      unique case (opcode)
         OP_LW, OP_ADDI: imm_type = IMM_I;
         OP_SW:          imm_type = IMM_S;
         OP_BEQ:         imm_type = IMM_B;
         OP_JAL:         imm_type = IMM_J;
         default:        imm_type = IMM_R;
      endcase
   end

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      iord           = 1'b0;
      ir_w_en        = 1'b0;
      pc_w_en        = 1'b0;
      pc_src         = 1'b0;
      alu_src1_is_pc = 1'b0;
      alu_src2_sel   = 2'b00;
      alu_op         = 1'b0;
      reg_w_en       = 1'b0;
      mem_to_reg     = 1'b0;
      retire         = 1'b0;
      err            = 1'b0;
      unique case (state_q)
         ST_IDLE: if (run) state_d = ST_FETCH;
         ST_FETCH: begin
            if (timeout) begin
               state_d = ST_ERR;
            end else begin
               mem_req        = 1'b1;
               alu_src1_is_pc = 1'b1;
               alu_src2_sel   = 2'b10;
               if (mem_ready) begin
                  ir_w_en = 1'b1;
                  pc_w_en = 1'b1;
                  state_d = ST_DECODE;
               end
            end
         end
         ST_DECODE: begin
            if (opcode inside {OP_LW, OP_ADDI, OP_SW, OP_ADD, OP_BEQ, OP_JAL}) state_d = ST_EXEC;
            else state_d = ST_ERR;
         end
         ST_EXEC: begin
            case (opcode)
               OP_ADD:  state_d = ST_WB;
               OP_ADDI: begin
                  alu_src2_sel = 2'b01;
                  state_d      = ST_WB;
               end
               OP_LW, OP_SW: begin
                  alu_src2_sel = 2'b01;
                  state_d      = ST_MEM;
               end
               OP_BEQ: begin
                  alu_op  = 1'b1;
                  pc_w_en = zero;
                  pc_src  = 1'b1;
                  retire  = 1'b1;
                  state_d = retire_next;
               end
               OP_JAL: begin
                  alu_src1_is_pc = 1'b1;
                  alu_src2_sel   = 2'b10;
                  reg_w_en       = 1'b1;
                  pc_w_en        = 1'b1;
                  pc_src         = 1'b1;
                  retire         = 1'b1;
                  state_d        = retire_next;
               end
               default: state_d = ST_ERR;
            endcase
         end
         ST_MEM: begin
            if (timeout) begin
               state_d = ST_ERR;
            end else begin
               mem_req = 1'b1;
               iord    = 1'b1;
               mem_we  = (opcode == OP_SW);
               if (mem_ready) begin
                  if (opcode == OP_SW) begin
                     retire  = 1'b1;
                     state_d = retire_next;
                  end else begin
                     state_d = ST_WB;
                  end
               end
            end
         end
         ST_WB: begin
            reg_w_en   = 1'b1;
            mem_to_reg = (opcode == OP_LW);
            retire     = 1'b1;
            state_d    = retire_next;
         end
         ST_ERR:  err = 1'b1;
         default: state_d = ST_ERR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   assign state = state_q;

`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d, inst_cnt_q, inst_cnt_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      inst_cnt_d  = inst_cnt_q;
      if (state_q inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (retire) inst_cnt_d = inst_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         inst_cnt_q  <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         inst_cnt_q  <= inst_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign inst_cnt  = inst_cnt_q;
`else
   assign cycle_cnt = '0;
   assign inst_cnt  = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences push one expected
// control vector per cycle; a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   localparam logic [31:0] I_ADDI = 32'h0050_0093;
   localparam logic [31:0] I_LW   = 32'h0000_A103;
   localparam logic [31:0] I_SW   = 32'h0020_A223;
   localparam logic [31:0] I_ADD  = 32'h0020_81B3;
   localparam logic [31:0] I_BEQ  = 32'h0020_8463;
   localparam logic [31:0] I_JAL  = 32'h0080_00EF;
   localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

   // vector bit order: mem_req mem_we iord ir_w_en pc_w_en pc_src src1_pc src2[1:0] alu_op reg_w_en mem_to_reg retire err
   localparam logic [13:0] M_ALL   = 14'h3FFF;
   localparam logic [13:0] M_NOALU = 14'h3F0F;

   logic        clk, rst, run, zero, mem_ready;
   logic [31:0] inst;
   logic [2:0]  state, imm_type;
   logic        mem_req, mem_we, iord, ir_w_en, pc_w_en, pc_src, alu_src1_is_pc, alu_op;
   logic [1:0]  alu_src2_sel;
   logic        reg_w_en, mem_to_reg, retire, err;
   logic [31:0] cycle_cnt, inst_cnt;
   logic [13:0] dut_vec;

   typedef struct {
      string       name;
      logic [2:0]  st;
      logic [13:0] vec;
      logic [13:0] mask;
      bit          chk_imm;
      logic [2:0]  imm;
      bit          chk_cnt;
      logic [31:0] cyc;
      logic [31:0] ins;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   multicycle_ctrl #(.WAIT_MAX(15)) dut (
      .clk(clk), .rst(rst), .run(run), .inst(inst), .zero(zero), .mem_ready(mem_ready),
      .state(state), .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_w_en(ir_w_en),
      .pc_w_en(pc_w_en), .pc_src(pc_src), .alu_src1_is_pc(alu_src1_is_pc),
      .alu_src2_sel(alu_src2_sel), .alu_op(alu_op), .imm_type(imm_type), .reg_w_en(reg_w_en),
      .mem_to_reg(mem_to_reg), .retire(retire), .err(err), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
   );

   assign dut_vec = {mem_req, mem_we, iord, ir_w_en, pc_w_en, pc_src, alu_src1_is_pc,
                     alu_src2_sel, alu_op, reg_w_en, mem_to_reg, retire, err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [13:0] v(input bit mreq, input bit we, input bit io, input bit ir,
                                     input bit pcw, input bit pcs, input bit s1, input logic [1:0] s2,
                                     input bit op, input bit rw, input bit m2r, input bit ret, input bit e);
      return {mreq, we, io, ir, pcw, pcs, s1, s2, op, rw, m2r, ret, e};
   endfunction

   task automatic expect_cyc(input string nm, input logic [2:0] st, input logic [13:0] vec,
                             input logic [13:0] mask, input bit ci = 1'b0, input logic [2:0] imm = 3'd0,
                             input bit cc = 1'b0, input logic [31:0] cyc = 32'd0, input logic [31:0] ins = 32'd0);
      exp_t e;
      e.name = nm; e.st = st; e.vec = vec; e.mask = mask;
      e.chk_imm = ci; e.imm = imm; e.chk_cnt = cc; e.cyc = cyc; e.ins = ins;
      sb_q.push_back(e);
   endtask

   task automatic drive(input bit r, input logic [31:0] i, input bit z, input bit rdy);
      @(posedge clk);
      #1;
      run = r; inst = i; zero = z; mem_ready = rdy;
   endtask

   task automatic x_idle(input string nm, input bit cc = 1'b0, input logic [31:0] cyc = 32'd0,
                         input logic [31:0] ins = 32'd0);
      expect_cyc(nm, 3'd0, 14'd0, M_NOALU, 1'b0, 3'd0, cc, cyc, ins);
   endtask

   task automatic x_fetch(input string nm, input bit rdy);
      expect_cyc(nm, 3'd1, v(1, 0, 0, rdy, rdy, 0, 1, 2'b10, 0, 0, 0, 0, 0), M_ALL);
   endtask

   task automatic x_decode(input string nm, input logic [2:0] imm);
      expect_cyc(nm, 3'd2, 14'd0, M_NOALU, 1'b1, imm);
   endtask

   task automatic x_mem(input string nm, input bit we, input bit rdy);
      expect_cyc(nm, 3'd4, v(1, we, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, we & rdy, 0), M_NOALU);
   endtask

   task automatic x_wb(input string nm, input bit lw);
      expect_cyc(nm, 3'd5, v(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, lw, 1, 0), M_NOALU);
   endtask

   task automatic x_err(input string nm);
      expect_cyc(nm, 3'd6, v(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1), M_NOALU);
   endtask

   // Register-register / immediate ALU instruction with mem_ready always high.
   task automatic do_alu(input string nm, input logic [31:0] i, input logic [2:0] imm,
                         input logic [1:0] s2, input bit run_after);
      drive(1, i, 0, 1); x_fetch({nm, "_fetch"}, 1'b1);
      drive(1, i, 0, 1); x_decode({nm, "_decode"}, imm);
      drive(1, i, 0, 1); expect_cyc({nm, "_exec"}, 3'd3, v(0, 0, 0, 0, 0, 0, 0, s2, 0, 0, 0, 0, 0), M_ALL);
      drive(run_after, i, 0, 1); x_wb({nm, "_wb"}, 1'b0);
   endtask

   // Reset asserted mid-cycle; outputs must be idle before the next clock edge.
   task automatic do_reset(input string nm);
      @(posedge clk);
      #2;
      rst = 1'b1; run = 1'b0;
      expect_cyc(nm, 3'd0, 14'd0, M_NOALU, 1'b0, 3'd0, 1'b1, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      bit   ok;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            ok = (state === e.st) && ((dut_vec & e.mask) === (e.vec & e.mask));
            if (e.chk_imm && (imm_type !== e.imm)) ok = 1'b0;
            if (e.chk_cnt && ((cycle_cnt !== e.cyc) || (inst_cnt !== e.ins))) ok = 1'b0;
            n_cmp++;
            if (!ok) begin
               n_bad++;
               $display("FAIL %s: got state=%0d vec=%b imm=%0d cyc=%0d ins=%0d; want state=%0d vec=%b mask=%b imm=%0d cyc=%0d ins=%0d",
                        e.name, state, dut_vec, imm_type, cycle_cnt, inst_cnt,
                        e.st, e.vec, e.mask, e.imm, e.cyc, e.ins);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      rst = 1'b1; run = 1'b0; inst = 32'd0; zero = 1'b0; mem_ready = 1'b1;
      do_reset("reset_init");

      // Three back-to-back addi: 1,2,3,5,1,... then halt; counters read 12 cycles / 3 retires.
      drive(1, I_ADDI, 0, 1); x_idle("idle_start", 1'b1, 32'd0, 32'd0);
      do_alu("addi0", I_ADDI, IMM_I, 2'b01, 1'b1);
      do_alu("addi1", I_ADDI, IMM_I, 2'b01, 1'b1);
      do_alu("addi2", I_ADDI, IMM_I, 2'b01, 1'b0);
`ifdef PERF_CNT_EN
      drive(1, I_LW, 0, 1); x_idle("perf_cnt", 1'b1, 32'd12, 32'd3);
`else
      drive(1, I_LW, 0, 1); x_idle("perf_cnt", 1'b1, 32'd0, 32'd0);
`endif

      // lw with three stalled MEM cycles.
      drive(1, I_LW, 0, 1); x_fetch("lw_fetch", 1'b1);
      drive(1, I_LW, 0, 1); x_decode("lw_decode", IMM_I);
      drive(1, I_LW, 0, 1); expect_cyc("lw_exec", 3'd3, v(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0), M_ALL);
      for (int k = 0; k < 3; k++) begin
         drive(1, I_LW, 0, 0); x_mem("lw_mem_stall", 1'b0, 1'b0);
      end
      drive(1, I_LW, 0, 1); x_mem("lw_mem_done", 1'b0, 1'b1);
      drive(1, I_LW, 0, 1); x_wb("lw_wb", 1'b1);

      // beq taken then not taken; both retire.
      drive(1, I_BEQ, 1, 1); x_fetch("beq1_fetch", 1'b1);
      drive(1, I_BEQ, 1, 1); x_decode("beq1_decode", IMM_B);
      drive(1, I_BEQ, 1, 1); expect_cyc("beq_taken", 3'd3, v(0, 0, 0, 0, 1, 1, 0, 2'b00, 1, 0, 0, 1, 0), M_ALL);
      drive(1, I_BEQ, 0, 1); x_fetch("beq0_fetch", 1'b1);
      drive(1, I_BEQ, 0, 1); x_decode("beq0_decode", IMM_B);
      drive(1, I_BEQ, 0, 1); expect_cyc("beq_not_taken", 3'd3, v(0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 0, 0, 1, 0), M_ALL);

      do_alu("add", I_ADD, IMM_R, 2'b00, 1'b1);

      drive(1, I_JAL, 0, 1); x_fetch("jal_fetch", 1'b1);
      drive(1, I_JAL, 0, 1); x_decode("jal_decode", IMM_J);
      drive(1, I_JAL, 0, 1); expect_cyc("jal_exec", 3'd3, v(0, 0, 0, 0, 1, 1, 1, 2'b10, 0, 1, 0, 1, 0), M_ALL);

      // sw with run dropped during FETCH: completes, then halts.
      drive(0, I_SW, 0, 1); x_fetch("sw_fetch", 1'b1);
      drive(0, I_SW, 0, 1); x_decode("sw_decode", IMM_S);
      drive(0, I_SW, 0, 1); expect_cyc("sw_exec", 3'd3, v(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0), M_ALL);
      drive(0, I_SW, 0, 1); x_mem("sw_mem", 1'b1, 1'b1);
      drive(0, I_SW, 0, 1); x_idle("sw_halt");

      // Fetch timeout: 15 mem_ready-low cycles, the last one issues no strobes.
      drive(1, I_ADDI, 0, 0); x_idle("to_idle");
      for (int k = 1; k < 15; k++) begin
         drive(1, I_ADDI, 0, 0); x_fetch("to_fetch_wait", 1'b0);
      end
      drive(1, I_ADDI, 0, 0); expect_cyc("to_fetch_last", 3'd1, 14'd0, M_NOALU);
      for (int k = 0; k < 3; k++) begin
         drive(1, I_ADDI, 0, 1); x_err("to_err_sticky");
      end
      do_reset("reset_after_timeout");

      // Illegal opcode goes DECODE -> ERR.
      drive(1, I_BAD, 0, 1); x_idle("bad_idle");
      drive(1, I_BAD, 0, 1); x_fetch("bad_fetch", 1'b1);
      drive(1, I_BAD, 0, 1); expect_cyc("bad_decode", 3'd2, 14'd0, M_NOALU);
      drive(1, I_BAD, 0, 1); x_err("bad_err");
      drive(1, I_BAD, 0, 1); x_err("bad_err_sticky");
      do_reset("reset_after_bad");

      // Reset while sw is stalled in MEM with mem_we high.
      drive(1, I_SW, 0, 1); x_idle("swr_idle");
      drive(1, I_SW, 0, 1); x_fetch("swr_fetch", 1'b1);
      drive(1, I_SW, 0, 1); x_decode("swr_decode", IMM_S);
      drive(1, I_SW, 0, 1); expect_cyc("swr_exec", 3'd3, v(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0), M_ALL);
      drive(1, I_SW, 0, 0); x_mem("swr_mem_we", 1'b1, 1'b0);
      do_reset("reset_mid_mem");
      drive(0, I_SW, 0, 1); x_idle("post_reset_idle");

      repeat (3) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
